// File: rtl/data_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundles the two requester ports (core, loader) and the single data-memory
// port that the arbiter sits between, plus the arbiter status outputs.
//   slave  : arbiter side (takes requests, drives acks/rdata and memory strobes)
//   master : environment side (requesters and memory model)
// Signals:
//   core_req/we/addr/wdata -> arbiter, core_ack/rdata <- arbiter
//   ldr_req/we/addr/wdata  -> arbiter, ldr_ack/rdata  <- arbiter
//   mem_addr/wdata/we/re   <- arbiter, mem_rdata      -> arbiter
//   busy, owner            <- arbiter
// -----------------------------------------------------------------------------
interface data_mem_arbiter_if;
    logic        core_req;
    logic        core_we;
    logic [63:0] core_addr;
    logic [63:0] core_wdata;
    logic        core_ack;
    logic [63:0] core_rdata;

    logic        ldr_req;
    logic        ldr_we;
    logic [63:0] ldr_addr;
    logic [63:0] ldr_wdata;
    logic        ldr_ack;
    logic [63:0] ldr_rdata;

    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [63:0] mem_rdata;

    logic        busy;
    logic        owner;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  mem_rdata,
        output core_ack, core_rdata, ldr_ack, ldr_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        output busy, owner
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output mem_rdata,
        input  core_ack, core_rdata, ldr_ack, ldr_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        input  busy, owner
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Serialises core and loader accesses onto the shared 64-bit data memory.
// Each transaction: one ISSUE cycle with a single strobe, LAT wait cycles for
// reads, then a one-cycle ack to the owning port. All outputs are registered.
//
// Parameters:
//   LAT       memory read latency in cycles (1..8)
//   MAX_WAIT  core grants tolerated while the loader waits (guard build only)
// Ports:
//   clock     rising-edge system clock
//   reset     asynchronous, active-high; abandons any in-flight transaction
//   bus       data_mem_arbiter_if.slave (requester ports, memory port, status)
//
// Build option: DATA_MEM_ARB_STARVE_GUARD_EN compiles in the loader
// starvation counter; otherwise the core has strict priority.
//
// state  | meaning
// IDLE   | arbitrate, latch winner's we/addr/wdata
// ISSUE  | one cycle with mem_we or mem_re high
// WAIT   | count down read latency, capture mem_rdata at zero
// RESP   | one-cycle ack to the owner port
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int LAT      = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] LAT_M1 = 3'(LAT - 1);

    state_t      r_state;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic        r_owner;
    logic [2:0]  r_cnt;
    logic        r_mem_we;
    logic        r_mem_re;
    logic        r_core_ack;
    logic        r_ldr_ack;
    logic [63:0] r_core_rdata;
    logic [63:0] r_ldr_rdata;
    logic        r_busy;

    logic        w_req_any;
    logic        w_grant_ldr;
    logic        w_force_ldr;
    logic        w_sel_we;
    logic [63:0] w_sel_addr;
    logic [63:0] w_sel_wdata;

`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    logic [3:0] r_starve;

    assign w_force_ldr = (r_starve == MAX_WAIT_C);

    // Only moves on IDLE cycles; saturates so an oversized MAX_WAIT never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_starve <= 4'd0;
        end else if (r_state == S_IDLE) begin
            if (!bus.ldr_req || w_grant_ldr) begin
                r_starve <= 4'd0;
            end else if (bus.core_req && r_starve != 4'hF) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end
`else
    localparam int unused_max_wait = MAX_WAIT;
    assign w_force_ldr = 1'b0;
`endif

    assign w_req_any   = bus.core_req | bus.ldr_req;
    assign w_grant_ldr = bus.ldr_req & (~bus.core_req | w_force_ldr);
    assign w_sel_we    = w_grant_ldr ? bus.ldr_we    : bus.core_we;
    assign w_sel_addr  = w_grant_ldr ? bus.ldr_addr  : bus.core_addr;
    assign w_sel_wdata = w_grant_ldr ? bus.ldr_wdata : bus.core_wdata;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_addr       <= 64'd0;
            r_wdata      <= 64'd0;
            r_owner      <= 1'b0;
            r_cnt        <= 3'd0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_core_ack   <= 1'b0;
            r_ldr_ack    <= 1'b0;
            r_core_rdata <= 64'd0;
            r_ldr_rdata  <= 64'd0;
            r_busy       <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses by default.
            r_mem_we   <= 1'b0;
            r_mem_re   <= 1'b0;
            r_core_ack <= 1'b0;
            r_ldr_ack  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_owner  <= w_grant_ldr;
                        r_we     <= w_sel_we;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        // Strobes registered here so they are high during ISSUE.
                        r_mem_we <= w_sel_we;
                        r_mem_re <= ~w_sel_we;
                        r_busy   <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_core_ack <= ~r_owner;
                        r_ldr_ack  <= r_owner;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt   <= LAT_M1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        if (r_owner) begin
                            r_ldr_rdata <= bus.mem_rdata;
                        end else begin
                            r_core_rdata <= bus.mem_rdata;
                        end
                        r_core_ack <= ~r_owner;
                        r_ldr_ack  <= r_owner;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_re     = r_mem_re;
    assign bus.core_ack   = r_core_ack;
    assign bus.core_rdata = r_core_rdata;
    assign bus.ldr_ack    = r_ldr_ack;
    assign bus.ldr_rdata  = r_ldr_rdata;
    assign bus.busy       = r_busy;
    assign bus.owner      = r_owner;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Three arbiter instances (LAT = 3, 1, 4) share one clock. Each has a memory
// model whose read data is valid only in the cycle LAT cycles after mem_re.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;
    localparam int NI = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [NI-1:0]        rst_v;
    logic [NI-1:0]        c_req, c_we, l_req, l_we;
    logic [NI-1:0][63:0]  c_addr, c_wdata, l_addr, l_wdata;
    wire  [NI-1:0]        c_ack, l_ack, m_we, m_re, busy, owner;
    wire  [NI-1:0][63:0]  c_rdata, l_rdata, m_addr, m_wdata;

    function automatic logic [63:0] mem_val(input logic [63:0] a);
        return {32'hDEADBEEF, a[31:0]};
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 3 : (gi == 1) ? 1 : 4;
        data_mem_arbiter_if bus();
        int          re_cyc  = -100;
        logic [63:0] re_addr = 64'd0;

        data_mem_arbiter #(.LAT(L), .MAX_WAIT(4)) u_dut (
            .clock (clock),
            .reset (rst_v[gi]),
            .bus   (bus)
        );

        assign bus.core_req   = c_req[gi];
        assign bus.core_we    = c_we[gi];
        assign bus.core_addr  = c_addr[gi];
        assign bus.core_wdata = c_wdata[gi];
        assign bus.ldr_req    = l_req[gi];
        assign bus.ldr_we     = l_we[gi];
        assign bus.ldr_addr   = l_addr[gi];
        assign bus.ldr_wdata  = l_wdata[gi];

        assign c_ack[gi]   = bus.core_ack;
        assign c_rdata[gi] = bus.core_rdata;
        assign l_ack[gi]   = bus.ldr_ack;
        assign l_rdata[gi] = bus.ldr_rdata;
        assign m_addr[gi]  = bus.mem_addr;
        assign m_wdata[gi] = bus.mem_wdata;
        assign m_we[gi]    = bus.mem_we;
        assign m_re[gi]    = bus.mem_re;
        assign busy[gi]    = bus.busy;
        assign owner[gi]   = bus.owner;

        always @(posedge clock) begin
            if (bus.mem_re) begin
                re_cyc  <= cyc;
                re_addr <= bus.mem_addr;
            end
        end
        assign bus.mem_rdata = (cyc == re_cyc + L) ? mem_val(re_addr)
                                                   : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // {busy, mem_we, mem_re, core_ack, ldr_ack, owner}
    function automatic logic [5:0] st(input int d);
        return {busy[d], m_we[d], m_re[d], c_ack[d], l_ack[d], owner[d]};
    endfunction

    typedef struct {
        int          inst;
        bit          port;    // 0 core, 1 loader
        bit          we;
        bit          early;   // drop req during ISSUE
        logic [63:0] addr;
        logic [63:0] wdata;
        int          ack_cyc;
        logic [63:0] rdata;   // owner rdata expected in the ack cycle
    } vec_t;

    vec_t vecs [8];

    task automatic set_req(input int d, input bit port, input bit v);
        if (port) l_req[d] = v;
        else      c_req[d] = v;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int          d;
        logic [5:0]  exp_st;
        logic [63:0] rd;
        d = v.inst;
        if (v.port) begin
            l_we[d] = v.we; l_addr[d] = v.addr; l_wdata[d] = v.wdata;
        end else begin
            c_we[d] = v.we; c_addr[d] = v.addr; c_wdata[d] = v.wdata;
        end
        set_req(d, v.port, 1'b1);
        for (int k = 1; k <= v.ack_cyc + 1; k++) begin
            @(negedge clock);
            exp_st = {k <= v.ack_cyc,
                      k == 1 && v.we,
                      k == 1 && !v.we,
                      k == v.ack_cyc && !v.port,
                      k == v.ack_cyc && v.port,
                      v.port};
            chk($sformatf("vec%0d_c%0d_status", idx, k), 64'(st(d)), 64'(exp_st));
            if (k == 1) begin
                chk($sformatf("vec%0d_mem_addr", idx), m_addr[d], v.addr);
                if (v.we) chk($sformatf("vec%0d_mem_wdata", idx), m_wdata[d], v.wdata);
                if (v.early) set_req(d, v.port, 1'b0);
            end
            if (k == v.ack_cyc) begin
                rd = v.port ? l_rdata[d] : c_rdata[d];
                chk($sformatf("vec%0d_rdata", idx), rd, v.rdata);
                set_req(d, v.port, 1'b0);
            end
        end
        set_req(d, v.port, 1'b0);
    endtask

    task automatic sim_pair(input bit we, input logic [63:0] ca, input logic [63:0] la,
                            output int c_at, output int l_at,
                            output logic [63:0] crd, output logic [63:0] lrd);
        c_at = -1; l_at = -1; crd = '0; lrd = '0;
        c_we[0] = we; c_addr[0] = ca; c_wdata[0] = ca + 64'd1;
        l_we[0] = we; l_addr[0] = la; l_wdata[0] = la + 64'd1;
        c_req[0] = 1'b1;
        l_req[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (c_ack[0] && c_at < 0) begin c_at = k; crd = c_rdata[0]; c_req[0] = 1'b0; end
            if (l_ack[0] && l_at < 0) begin l_at = k; lrd = l_rdata[0]; l_req[0] = 1'b0; end
        end
        c_req[0] = 1'b0;
        l_req[0] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c_at, l_at, n_core, exp_n, exp_l;
        bit          drop_pending;
        logic [63:0] crd, lrd;
        vec_t        vr;

        rst_v = '1;
        c_req = '0; c_we = '0; c_addr = '0; c_wdata = '0;
        l_req = '0; l_we = '0; l_addr = '0; l_wdata = '0;

        //          inst port we early addr     wdata        ack rdata
        vecs[0] = '{0, 1'b0, 1'b0, 1'b0, 64'h10, 64'h0,    5, 64'hDEADBEEF_00000010};
        vecs[1] = '{0, 1'b1, 1'b1, 1'b0, 64'h28, 64'h5,    2, 64'h0};
        vecs[2] = '{0, 1'b0, 1'b1, 1'b0, 64'h30, 64'h1234, 2, 64'hDEADBEEF_00000010};
        vecs[3] = '{0, 1'b0, 1'b0, 1'b1, 64'h60, 64'h0,    5, 64'hDEADBEEF_00000060};
        vecs[4] = '{1, 1'b0, 1'b0, 1'b0, 64'h40, 64'h0,    3, 64'hDEADBEEF_00000040};
        vecs[5] = '{1, 1'b1, 1'b0, 1'b0, 64'h18, 64'h0,    3, 64'hDEADBEEF_00000018};
        vecs[6] = '{2, 1'b1, 1'b0, 1'b0, 64'h88, 64'h0,    6, 64'hDEADBEEF_00000088};
        vecs[7] = '{2, 1'b0, 1'b1, 1'b0, 64'h90, 64'hFFFF, 2, 64'h0};

        repeat (2) @(negedge clock);
        for (int d = 0; d < NI; d++) begin
            chk($sformatf("rst_status_%0d", d), 64'(st(d)), 64'd0);
            chk($sformatf("rst_data_%0d", d), c_rdata[d] | l_rdata[d] | m_addr[d] | m_wdata[d], 64'd0);
        end
        rst_v = '0;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], i);
            @(negedge clock);
        end

        // Simultaneous requests: core first, loader right after.
        sim_pair(1'b1, 64'h50, 64'h58, c_at, l_at, crd, lrd);
        chk("simul_wr_core_ack_cyc", 64'(c_at), 64'd2);
        chk("simul_wr_ldr_ack_cyc",  64'(l_at), 64'd5);
        sim_pair(1'b0, 64'h70, 64'h78, c_at, l_at, crd, lrd);
        chk("simul_rd_core_ack_cyc", 64'(c_at), 64'd5);
        chk("simul_rd_ldr_ack_cyc",  64'(l_at), 64'd11);
        chk("simul_rd_core_rdata", crd, 64'hDEADBEEF_00000070);
        chk("simul_rd_ldr_rdata",  lrd, 64'hDEADBEEF_00000078);
        repeat (2) @(negedge clock);

        // Starvation: core writes back-to-back, loader held high.
`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
        exp_n = 4;  exp_l = 14;
`else
        exp_n = 14; exp_l = 44;
`endif
        n_core = 0; l_at = -1; drop_pending = 1'b0;
        c_we[0] = 1'b1; c_addr[0] = 64'h100; c_wdata[0] = 64'h1;
        l_we[0] = 1'b1; l_addr[0] = 64'h200; l_wdata[0] = 64'h2;
        c_req[0] = 1'b1;
        l_req[0] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clock);
            if (l_at < 0) begin
                if (k == 40) drop_pending = 1'b1;
                if (c_ack[0]) begin
                    n_core++;
                    if (drop_pending) c_req[0] = 1'b0;
                end
                if (l_ack[0]) begin
                    l_at = k;
                    c_req[0] = 1'b0;
                    l_req[0] = 1'b0;
                end
            end
        end
        c_req[0] = 1'b0;
        l_req[0] = 1'b0;
        chk("starve_core_grants", 64'(n_core), 64'(exp_n));
        chk("starve_ldr_ack_cyc", 64'(l_at), 64'(exp_l));
        @(negedge clock);

        // Reset in the second WAIT cycle of a LAT=4 read.
        c_we[2] = 1'b0; c_addr[2] = 64'h20;
        c_req[2] = 1'b1;
        repeat (3) @(negedge clock);
        chk("rstmid_pre_status", 64'(st(2)), 64'(6'b100000));
        rst_v[2] = 1'b1;
        c_req[2] = 1'b0;
        #1;
        chk("rstmid_async_status", 64'(st(2)), 64'd0);
        @(negedge clock);
        chk("rstmid_held_status", 64'(st(2)), 64'd0);
        rst_v[2] = 1'b0;
        @(negedge clock);
        vr = '{2, 1'b0, 1'b0, 1'b0, 64'h30, 64'h0, 6, 64'hDEADBEEF_00000030};
        run_txn(vr, 8);
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
